slc3_mem_arbiter: RTL and testbench

//  Shares the single SRAM/BRAM port between two requesters: port 0 = SLC-3 CPU
//  (MAR/MDR path via Mem2IO), port 1 = program loader/debug DMA. Sits between the

---
 rtl/slc3_arb_pkg.sv | 14 +
 rtl/slc3_mem_arbiter_rr_pick2.sv | 19 +
 rtl/slc3_mem_arbiter.sv | 109 ++++++++++
 tb/tb_slc3_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_arb_pkg.sv
// Shared types for the SLC-3 memory arbiter: FSM states and port identifiers.
package slc3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam int NUM_PORTS = 2;

endpackage

// File: rtl/slc3_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that
// did not win last time.
module rr_pick2
  import slc3_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_gnt,
  output logic                 valid,
  output logic                 winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) winner = ~last_gnt;
    else              winner = req[1];
  end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Shares one SRAM port between the SLC-3 CPU (port 0) and the loader/DMA
// (port 1): round-robin grant, fixed-latency access, one-cycle ack.
//
// state  | meaning
// IDLE   | no transaction; sample req and grant a winner
// ACCESS | OE or WE held for MEM_LAT cycles; read data sampled on the last edge
// RESP   | ack pulsed to the granted port for one cycle
module slc3_mem_arbiter
  import slc3_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] we,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [DATA_W-1:0]    wdata0,
  input  logic [DATA_W-1:0]    wdata1,
  output logic [NUM_PORTS-1:0] ack,
  output logic [DATA_W-1:0]    rdata,
  output logic                 busy,
  output logic                 gnt_id,
  output logic [ADDR_W-1:0]    ADDR,
  output logic                 OE,
  output logic                 WE,
  output logic [DATA_W-1:0]    Data_to_SRAM,
  input  logic [DATA_W-1:0]    Data_from_SRAM
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             last_gnt;
  logic             pick_valid;
  logic             pick_winner;

  rr_pick2 u_pick (
    .req    (req),
    .last_gnt(last_gnt),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      last_gnt     <= 1'b1;
      ack          <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      gnt_id       <= 1'b0;
      ADDR         <= '0;
      OE           <= 1'b0;
      WE           <= 1'b0;
      Data_to_SRAM <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (pick_valid) begin
            gnt_id       <= pick_winner;
            last_gnt     <= pick_winner;
            ADDR         <= pick_winner ? addr1 : addr0;
            Data_to_SRAM <= pick_winner ? wdata1 : wdata0;
            we_q         <= we[pick_winner];
            OE           <= ~we[pick_winner];
            WE           <= we[pick_winner];
            cnt          <= CNT_W'(MEM_LAT - 1);
            busy         <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // OE/WE stay registered high until the terminal count edge
          if (cnt == '0) begin
            OE    <= 1'b0;
            WE    <= 1'b0;
            ack   <= gnt_id ? 2'b10 : 2'b01;
            state <= RESP;
            if (!we_q) rdata <= Data_from_SRAM;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= '0;
          OE    <= 1'b0;
          WE    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed bench for slc3_mem_arbiter: main build MEM_LAT=2 plus MEM_LAT=1/4
// builds sharing the same stimulus for latency checks.
module tb_slc3_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  req, we;
  logic [15:0] addr0, addr1, wdata0, wdata1, mem_data;

  logic [1:0]  ack, ack_l1, ack_l4;
  logic [15:0] rdata, rdata_l1, rdata_l4;
  logic        busy, busy_l1, busy_l4;
  logic        gnt_id, gnt_l1, gnt_l4;
  logic [15:0] ADDR, addr_l1, addr_l4;
  logic        OE, oe_l1, oe_l4;
  logic        WE, we_l1, we_l4;
  logic [15:0] Data_to_SRAM, dts_l1, dts_l4;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  slc3_mem_arbiter #(.MEM_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rdata(rdata), .busy(busy),
    .gnt_id(gnt_id), .ADDR(ADDR), .OE(OE), .WE(WE), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(mem_data));

  slc3_mem_arbiter #(.MEM_LAT(1)) dut_l1 (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack_l1), .rdata(rdata_l1), .busy(busy_l1),
    .gnt_id(gnt_l1), .ADDR(addr_l1), .OE(oe_l1), .WE(we_l1), .Data_to_SRAM(dts_l1),
    .Data_from_SRAM(mem_data));

  slc3_mem_arbiter #(.MEM_LAT(4)) dut_l4 (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack_l4), .rdata(rdata_l4), .busy(busy_l4),
    .gnt_id(gnt_l4), .ADDR(addr_l4), .OE(oe_l4), .WE(we_l4), .Data_to_SRAM(dts_l4),
    .Data_from_SRAM(mem_data));

  a_no_oe_we:    assert property (@(posedge Clk) !(OE && WE));
  a_no_oe_we_l1: assert property (@(posedge Clk) !(oe_l1 && we_l1));
  a_no_oe_we_l4: assert property (@(posedge Clk) !(oe_l4 && we_l4));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 2'b00; we = 2'b00; addr0 = 16'hAAAA; addr1 = 16'h5555;
    wdata0 = 16'h1111; wdata1 = 16'h2222; mem_data = 16'hDEAD;
    do_reset();
    tests++;
    if ({ack, OE, WE, busy, gnt_id} !== 6'b0 || ADDR !== 16'h0 ||
        rdata !== 16'h0 || Data_to_SRAM !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: ack=%b OE=%b WE=%b busy=%b gnt=%b ADDR=%h rdata=%h dts=%h, want all 0",
               ack, OE, WE, busy, gnt_id, ADDR, rdata, Data_to_SRAM);
    end
  endtask

  task automatic test_read_port0();
    req = 2'b01; we = 2'b00; addr0 = 16'h3000; mem_data = 16'h1234;
    tick();
    tests++;
    if (OE !== 1'b1 || WE !== 1'b0 || ADDR !== 16'h3000 || busy !== 1'b1 ||
        gnt_id !== 1'b0 || ack !== 2'b00) begin
      fails++;
      $display("FAIL read_cyc1: OE=%b WE=%b ADDR=%h busy=%b gnt=%b ack=%b, want 1 0 3000 1 0 00",
               OE, WE, ADDR, busy, gnt_id, ack);
    end
    tick();
    tests++;
    if (OE !== 1'b1 || WE !== 1'b0 || ack !== 2'b00) begin
      fails++;
      $display("FAIL read_cyc2: OE=%b WE=%b ack=%b, want 1 0 00", OE, WE, ack);
    end
    tick();
    tests++;
    if (ack !== 2'b01 || OE !== 1'b0 || rdata !== 16'h1234) begin
      fails++;
      $display("FAIL read_ack: ack=%b OE=%b rdata=%h, want 01 0 1234", ack, OE, rdata);
    end
    req = 2'b00;
    tick();
    tests++;
    if (ack !== 2'b00 || busy !== 1'b0 || rdata !== 16'h1234) begin
      fails++;
      $display("FAIL read_done: ack=%b busy=%b rdata=%h, want 00 0 1234", ack, busy, rdata);
    end
  endtask

  task automatic test_write_port1();
    req = 2'b10; we = 2'b10; addr1 = 16'h0040; wdata1 = 16'hBEEF; mem_data = 16'h9999;
    tick();
    tests++;
    if (WE !== 1'b1 || OE !== 1'b0 || ADDR !== 16'h0040 ||
        Data_to_SRAM !== 16'hBEEF || gnt_id !== 1'b1) begin
      fails++;
      $display("FAIL write_cyc1: WE=%b OE=%b ADDR=%h dts=%h gnt=%b, want 1 0 0040 BEEF 1",
               WE, OE, ADDR, Data_to_SRAM, gnt_id);
    end
    tick();
    tests++;
    if (WE !== 1'b1 || OE !== 1'b0 || ack !== 2'b00) begin
      fails++;
      $display("FAIL write_cyc2: WE=%b OE=%b ack=%b, want 1 0 00", WE, OE, ack);
    end
    tick();
    tests++;
    if (ack !== 2'b10 || WE !== 1'b0 || rdata !== 16'h1234 ||
        ADDR !== 16'h0040 || Data_to_SRAM !== 16'hBEEF) begin
      fails++;
      $display("FAIL write_ack: ack=%b WE=%b rdata=%h ADDR=%h dts=%h, want 10 0 1234 0040 BEEF",
               ack, WE, rdata, ADDR, Data_to_SRAM);
    end
    req = 2'b00; we = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    req = 2'b11; we = 2'b00; addr0 = 16'h0100; addr1 = 16'h0200; mem_data = 16'h0042;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (gnt_id !== 1'(k % 2) || busy !== 1'b1 || OE !== 1'b1 ||
          ADDR !== ((k % 2 == 1) ? 16'h0200 : 16'h0100)) begin
        fails++;
        $display("FAIL rr_grant%0d: gnt=%b busy=%b OE=%b ADDR=%h, want gnt=%0d busy=1 OE=1",
                 k, gnt_id, busy, OE, ADDR, k % 2);
      end
      tick();
      tick();
      tests++;
      if (ack !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_ack%0d: ack=%b, want %b", k, ack, (k % 2 == 1) ? 2'b10 : 2'b01);
      end
      tick();
      tests++;
      if (ack !== 2'b00 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rr_idle%0d: ack=%b busy=%b, want 00 0", k, ack, busy);
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_access();
    req = 2'b01; we = 2'b00; addr0 = 16'h1111;
    tick();
    tick();
    Reset = 1'b1; req = 2'b00;
    tick();
    tests++;
    if (OE !== 1'b0 || WE !== 1'b0 || ack !== 2'b00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort: OE=%b WE=%b ack=%b busy=%b, want 0 0 00 0", OE, WE, ack, busy);
    end
    Reset = 1'b0;
    tick();
    tests++;
    if (ack !== 2'b00) begin
      fails++;
      $display("FAIL abort_noack: ack=%b, want 00", ack);
    end
    req = 2'b11; addr0 = 16'h4321; addr1 = 16'h8765; mem_data = 16'hCAFE;
    tick();
    tests++;
    if (gnt_id !== 1'b0 || OE !== 1'b1 || ADDR !== 16'h4321) begin
      fails++;
      $display("FAIL post_reset_grant: gnt=%b OE=%b ADDR=%h, want 0 1 4321", gnt_id, OE, ADDR);
    end
    tick();
    tick();
    tests++;
    if (ack !== 2'b01 || rdata !== 16'hCAFE) begin
      fails++;
      $display("FAIL post_reset_ack: ack=%b rdata=%h, want 01 CAFE", ack, rdata);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_drop_and_queue();
    req = 2'b01; we = 2'b00; addr0 = 16'h2222; mem_data = 16'h5555;
    tick();
    req = 2'b10; addr1 = 16'h0077;
    tick();
    tick();
    tests++;
    if (ack !== 2'b01 || rdata !== 16'h5555) begin
      fails++;
      $display("FAIL drop_ack: ack=%b rdata=%h, want 01 5555", ack, rdata);
    end
    mem_data = 16'h7777;
    tick();
    tests++;
    if (ack !== 2'b00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_idle: ack=%b busy=%b, want 00 0", ack, busy);
    end
    tick();
    tests++;
    if (gnt_id !== 1'b1 || OE !== 1'b1 || ADDR !== 16'h0077) begin
      fails++;
      $display("FAIL queued_grant: gnt=%b OE=%b ADDR=%h, want 1 1 0077", gnt_id, OE, ADDR);
    end
    tick();
    tick();
    tests++;
    if (ack !== 2'b10 || rdata !== 16'h7777) begin
      fails++;
      $display("FAIL queued_ack: ack=%b rdata=%h, want 10 7777", ack, rdata);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_latency_builds();
    int first_l1, first_m, first_l4;
    int oe_l1_n, oe_m_n, oe_l4_n;
    first_l1 = -1; first_m = -1; first_l4 = -1;
    oe_l1_n = 0; oe_m_n = 0; oe_l4_n = 0;
    req = 2'b00; we = 2'b00; addr0 = 16'h0ABC; mem_data = 16'h0F0F;
    do_reset();
    req = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (first_l1 < 0 && oe_l1) oe_l1_n++;
      if (first_m  < 0 && OE)    oe_m_n++;
      if (first_l4 < 0 && oe_l4) oe_l4_n++;
      if (first_l1 < 0 && ack_l1 == 2'b01) first_l1 = c;
      if (first_m  < 0 && ack    == 2'b01) first_m  = c;
      if (first_l4 < 0 && ack_l4 == 2'b01) first_l4 = c;
      tests++;
      if ((OE && WE) || (oe_l1 && we_l1) || (oe_l4 && we_l4)) begin
        fails++;
        $display("FAIL oe_we_excl cycle %0d: OE/WE both high", c);
      end
    end
    req = 2'b00;
    tests++;
    if (first_l1 != 2 || first_m != 3 || first_l4 != 5) begin
      fails++;
      $display("FAIL latency: ack cycles l1=%0d l2=%0d l4=%0d, want 2 3 5", first_l1, first_m, first_l4);
    end
    tests++;
    if (oe_l1_n != 1 || oe_m_n != 2 || oe_l4_n != 4) begin
      fails++;
      $display("FAIL oe_width: l1=%0d l2=%0d l4=%0d, want 1 2 4", oe_l1_n, oe_m_n, oe_l4_n);
    end
    tests++;
    if (rdata_l4 !== 16'h0F0F || rdata_l1 !== 16'h0F0F) begin
      fails++;
      $display("FAIL latency_rdata: l1=%h l4=%h, want 0F0F", rdata_l1, rdata_l4);
    end
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    test_reset();
    test_read_port0();
    test_write_port1();
    test_round_robin();
    test_reset_mid_access();
    test_drop_and_queue();
    test_latency_builds();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
